// File: rtl/regfile_exec_sequencer.sv
// Multicycle execute stage: reads two operands from the 8x16 regfile, shifts B,
// runs the ALU, writes the result back and reports Z/N/V flags.
module regfile_exec_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [1:0]       shift,
    input  logic [2:0]       rn,
    input  logic [2:0]       rm,
    input  logic [2:0]       rd,
    output logic [2:0]       readnum,
    input  logic [WIDTH-1:0] data_out,
    output logic [2:0]       writenum,
    output logic             write,
    output logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] result,
    output logic             z_flag,
    output logic             n_flag,
    output logic             v_flag,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_A = 3'd1;
    localparam logic [2:0] S_LOAD_B = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_WRITE  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_NOT = 2'b11;

    logic [2:0]       r_state;
    logic [1:0]       r_op;
    logic [1:0]       r_shift;
    logic [2:0]       r_rn;
    logic [2:0]       r_rm;
    logic [2:0]       r_rd;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;
    logic             r_z;
    logic             r_n;
    logic             r_v;

    logic [WIDTH-1:0] w_bs;
    logic [WIDTH:0]   w_alu;

    function automatic logic [WIDTH-1:0] f_shift(input logic [1:0] sh,
                                                 input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] s;
        case (sh)
            2'b01:   s = {b[WIDTH-2:0], 1'b0};
            2'b10:   s = {1'b0, b[WIDTH-1:1]};
            2'b11:   s = {b[WIDTH-1], b[WIDTH-1:1]};
            default: s = b;
        endcase
        return s;
    endfunction

    // Returns {overflow, result}; overflow only meaningful for ADD/SUB.
    function automatic logic [WIDTH:0] f_alu(input logic [1:0] o,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] res;
        logic             v;
        res = '0;
        v   = 1'b0;
        case (o)
            OP_ADD: begin
                res = a + b;
                v   = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                res = a - b;
                v   = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  res = a & b;
            OP_NOT:  res = ~b;
            default: res = '0;
        endcase
        return {v, res};
    endfunction

    assign w_bs  = f_shift(r_shift, r_b);
    assign w_alu = f_alu(r_op, r_a, w_bs);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_shift  <= '0;
            r_rn     <= '0;
            r_rm     <= '0;
            r_rd     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_z      <= 1'b0;
            r_n      <= 1'b0;
            r_v      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op    <= op;
                        r_shift <= shift;
                        r_rn    <= rn;
                        r_rm    <= rm;
                        r_rd    <= rd;
                        r_state <= S_LOAD_A;
                    end
                end
                S_LOAD_A: begin
                    r_a     <= data_out;
                    r_state <= S_LOAD_B;
                end
                S_LOAD_B: begin
                    r_b     <= data_out;
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_result <= w_alu[WIDTH-1:0];
                    r_z      <= (w_alu[WIDTH-1:0] == '0);
                    r_n      <= w_alu[WIDTH-1];
                    r_v      <= w_alu[WIDTH];
                    r_state  <= S_WRITE;
                end
                S_WRITE: r_state <= S_DONE;
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        readnum = 3'd0;
        case (r_state)
            S_LOAD_A: readnum = r_rn;
            S_LOAD_B: readnum = r_rm;
            default:  readnum = 3'd0;
        endcase
    end

    // Decoded straight from state so a reset in WRITE drops the enable at once.
    assign write    = (r_state == S_WRITE);
    assign done     = (r_state == S_DONE);
    assign busy     = (r_state != S_IDLE);
    assign writenum = r_rd;
    assign data_in  = r_result;
    assign result   = r_result;
    assign z_flag   = r_z;
    assign n_flag   = r_n;
    assign v_flag   = r_v;

endmodule
